// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundles the MEM-stage request/response signals and the
// data_mem access signals of lsu_ctrl.
//   slave  modport: the lsu_ctrl side (takes requests, drives data_mem)
//   master modport: the pipeline + data_mem side
// Optional feature macro: LSU_MISALIGN_TRAP_EN adds omisalign.
interface lsu_ctrl_if #(
  parameter int unsigned MP_WIDTH = 32
);
  logic                ivalid;
  logic                iload;
  logic                istore;
  logic [2:0]          ifunct3;
  logic [MP_WIDTH-1:0] iaddr;
  logic [MP_WIDTH-1:0] iwdata;
  logic                obusy;
  logic                odone;
  logic [MP_WIDTH-1:0] ordata;
  logic [MP_WIDTH-1:0] opos;
  logic                owen;
  logic [1:0]          obe;
  logic [MP_WIDTH-1:0] owdata;
  logic [MP_WIDTH-1:0] irdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                omisalign;
`endif

  modport slave (
    input  ivalid, iload, istore, ifunct3, iaddr, iwdata, irdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output omisalign,
`endif
    output obusy, odone, ordata, opos, owen, obe, owdata
  );

  modport master (
    output ivalid, iload, istore, ifunct3, iaddr, iwdata, irdata,
`ifdef LSU_MISALIGN_TRAP_EN
    input  omisalign,
`endif
    input  obusy, odone, ordata, opos, owen, obe, owdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store initiator for data_mem.
// Aligned accesses (word@00, half@00/01/10, any byte) take one cycle with the
// access driven combinationally in the accept cycle; odone/ordata follow one
// cycle later. Misaligned words and halfwords at offset 11 are split into
// ascending byte accesses while obusy stalls the pipeline.
// Ports:
//   iclk, irst      clock, synchronous active-high reset
//   bus (slave)     ivalid/iload/istore/ifunct3/iaddr/iwdata request,
//                   obusy/odone/ordata response,
//                   opos/owen/obe/owdata/irdata data_mem access
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- split-class requests do no
// access and pulse omisalign with odone instead.
module lsu_ctrl #(
  parameter int unsigned MP_WIDTH = 32
) (
  input logic      iclk,
  input logic      irst,
  lsu_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE, S_SPLIT} state_t;

  state_t              state;
  logic [1:0]          cnt;
  logic [1:0]          last;
  logic [MP_WIDTH-1:0] sp_addr;
  logic [MP_WIDTH-1:0] sp_wdata;
  logic [2:0]          sp_f3;
  logic                sp_store;
  logic [MP_WIDTH-1:0] asm_q;
  logic [MP_WIDTH-1:0] hold_pos;
  logic [MP_WIDTH-1:0] hold_wdata;
  logic [1:0]          hold_be;
  logic                obusy_q;
  logic                odone_q;
  logic [MP_WIDTH-1:0] ordata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                omis_q;
`endif

  logic                req;
  logic                is_st;
  logic                illegal;
  logic                split;
  logic                access;
  logic [1:0]          sz;
  logic [MP_WIDTH-1:0] pos_c;
  logic [MP_WIDTH-1:0] wd_c;
  logic [1:0]          be_c;
  logic                wen_c;
  logic [MP_WIDTH-1:0] lane;
  logic [MP_WIDTH-1:0] asm_next;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'b0, raw[7:0]};
      3'b101:  return {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // A request is only considered in IDLE; reset in the same cycle drops it
  // before it can reach data_mem.
  assign req     = (state == S_IDLE) && bus.ivalid && (bus.iload || bus.istore) && !irst;
  assign is_st   = bus.istore && !bus.iload;
  assign sz      = bus.ifunct3[1:0];
  assign illegal = (sz == 2'b11) || (bus.ifunct3[2] && (is_st || sz == 2'b10));
  assign split   = ((sz == 2'b10) && (bus.iaddr[1:0] != 2'b00)) ||
                   ((sz == 2'b01) && (bus.iaddr[1:0] == 2'b11));
`ifdef LSU_MISALIGN_TRAP_EN
  assign access  = req && !illegal && !split;
`else
  assign access  = req && !illegal;
`endif

  // Memory-side drive: split bytes from latched request, new access straight
  // from the inputs, otherwise hold the last driven value.
  always_comb begin
    pos_c = hold_pos;
    be_c  = hold_be;
    wd_c  = hold_wdata;
    wen_c = 1'b0;
    if (state == S_SPLIT) begin
      pos_c = sp_addr + {30'b0, cnt};
      be_c  = 2'b00;
      wd_c  = {24'b0, sp_wdata[{cnt, 3'b000} +: 8]};
      wen_c = sp_store && !irst;
    end else if (access) begin
      pos_c = bus.iaddr;
      be_c  = split ? 2'b00 : sz;
      wd_c  = split ? {24'b0, bus.iwdata[7:0]} : bus.iwdata;
      wen_c = is_st;
    end
  end

  // irdata is the whole word holding opos; shift the addressed lane down.
  assign lane = bus.irdata >> {pos_c[1:0], 3'b000};

  always_comb begin
    asm_next = asm_q;
    asm_next[{cnt, 3'b000} +: 8] = lane[7:0];
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last       <= '0;
      sp_addr    <= '0;
      sp_wdata   <= '0;
      sp_f3      <= '0;
      sp_store   <= 1'b0;
      asm_q      <= '0;
      hold_pos   <= '0;
      hold_wdata <= '0;
      hold_be    <= '0;
      obusy_q    <= 1'b0;
      odone_q    <= 1'b0;
      ordata_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      omis_q     <= 1'b0;
`endif
    end else begin
      odone_q    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      omis_q     <= 1'b0;
`endif
      hold_pos   <= pos_c;
      hold_be    <= be_c;
      hold_wdata <= wd_c;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            if (illegal) begin
              odone_q  <= 1'b1;
              ordata_q <= '0;
            end else if (split) begin
`ifdef LSU_MISALIGN_TRAP_EN
              odone_q  <= 1'b1;
              omis_q   <= 1'b1;
              ordata_q <= '0;
`else
              // Byte 0 goes out this cycle; SPLIT continues from byte 1.
              sp_addr  <= bus.iaddr;
              sp_wdata <= bus.iwdata;
              sp_f3    <= bus.ifunct3;
              sp_store <= is_st;
              last     <= (sz == 2'b10) ? 2'd3 : 2'd1;
              asm_q    <= {24'b0, lane[7:0]};
              cnt      <= 2'd1;
              obusy_q  <= 1'b1;
              state    <= S_SPLIT;
`endif
            end else begin
              odone_q  <= 1'b1;
              ordata_q <= is_st ? '0 : extend(lane, bus.ifunct3);
            end
          end
        end
        S_SPLIT: begin
          asm_q <= asm_next;
          cnt   <= cnt + 2'd1;
          if (cnt == last) begin
            state    <= S_IDLE;
            obusy_q  <= 1'b0;
            odone_q  <= 1'b1;
            ordata_q <= sp_store ? '0 : extend(asm_next, sp_f3);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.obusy  = obusy_q;
  assign bus.odone  = odone_q;
  assign bus.ordata = ordata_q;
  assign bus.opos   = pos_c;
  assign bus.obe    = be_c;
  assign bus.owdata = wd_c;
  assign bus.owen   = wen_c;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.omisalign = omis_q;
`endif

endmodule
